// File: rtl/spi_master_shift.sv
// spi_master_shift: SPI mode-0 master serializer.
// Pulls bytes from the upstream FIFO stage (data_to_mosi / spi_cs), shifts them
// out MSB-first on MOSI while capturing MISO on each SCLK rising edge, and keeps
// CS_N low across back-to-back bytes while the enable stays high.
`timescale 1ns/1ps

module spi_master_shift #(
   parameter int CLK_DIV = 4,
   parameter int DSIZE   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DSIZE-1:0] data_to_mosi,
   input  logic             spi_cs,
   input  logic             miso,
   output logic             sclk,
   output logic             mosi,
   output logic             cs_n,
   output logic             byte_ack,
   output logic [DSIZE-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy
);

   localparam int             BW          = (DSIZE > 1) ? $clog2(DSIZE) : 1;
   localparam logic [7:0]     LP_DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [BW-1:0]  LP_BIT_LAST = BW'(DSIZE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [7:0]       r_div_cnt;
   logic [BW-1:0]    r_bit_cnt;
   logic             r_guard_done;
   logic [DSIZE-1:0] r_tx_sr;
   logic [DSIZE-1:0] r_rx_sr;
   logic             r_sclk;
   logic             r_cs_n;
   logic             r_byte_ack;
   logic [DSIZE-1:0] r_rx_data;
   logic             r_rx_valid;
   logic             r_busy;

   logic             w_tick;
   logic             w_load;
   logic             w_sample;
   logic             w_fall;
   logic             w_shift;
   logic             w_finish;
   logic             w_release;

   assign w_tick = (r_div_cnt == LP_DIV_LAST);

   // Next-state decode and per-edge action strobes for the datapath.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_sample     = 1'b0;
      w_fall       = 1'b0;
      w_shift      = 1'b0;
      w_finish     = 1'b0;
      w_release    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // The guard flag covers the time after reset; the tick covers the
            // edge on which the minimum CS_N high time is first reached.
            if ((r_guard_done || w_tick) && spi_cs) begin
               w_load       = 1'b1;
               w_state_next = ST_LOW;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_LOW: begin
            if (w_tick) begin
               w_sample     = 1'b1;
               w_state_next = ST_HIGH;
            end else begin
               w_state_next = ST_LOW;
            end
         end
         ST_HIGH: begin
            if (w_tick) begin
               w_fall = 1'b1;
               if (r_bit_cnt == LP_BIT_LAST) begin
                  w_state_next = ST_HOLD;
               end else begin
                  w_shift      = 1'b1;
                  w_state_next = ST_LOW;
               end
            end else begin
               w_state_next = ST_HIGH;
            end
         end
         ST_HOLD: begin
            if (w_tick) begin
               w_finish = 1'b1;
               if (spi_cs) begin
                  w_load       = 1'b1;
                  w_state_next = ST_LOW;
               end else begin
                  w_release    = 1'b1;
                  w_state_next = ST_IDLE;
               end
            end else begin
               w_state_next = ST_HOLD;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State register, divider, bit counter and CS_N guard flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_div_cnt    <= 8'd0;
         r_bit_cnt    <= '0;
         r_guard_done <= 1'b1;
         r_busy       <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_busy  <= (w_state_next != ST_IDLE);
         if ((w_state_next != r_state) || w_tick) begin
            r_div_cnt <= 8'd0;
         end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
         end
         if (w_load) begin
            r_bit_cnt <= '0;
         end else if (w_shift) begin
            r_bit_cnt <= r_bit_cnt + {{(BW-1){1'b0}}, 1'b1};
         end
         if (w_release) begin
            r_guard_done <= 1'b0;
         end else if ((r_state == ST_IDLE) && w_tick) begin
            r_guard_done <= 1'b1;
         end
      end
   end

   // Shift registers and registered SPI/handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tx_sr    <= '0;
         r_rx_sr    <= '0;
         r_sclk     <= 1'b0;
         r_cs_n     <= 1'b1;
         r_byte_ack <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_byte_ack <= w_load;
         r_rx_valid <= w_finish;
         if (w_load) begin
            r_tx_sr <= data_to_mosi;
         end else if (w_shift) begin
            r_tx_sr <= {r_tx_sr[DSIZE-2:0], 1'b0};
         end
         if (w_sample) begin
            r_rx_sr <= {r_rx_sr[DSIZE-2:0], miso};
         end
         if (w_sample) begin
            r_sclk <= 1'b1;
         end else if (w_fall) begin
            r_sclk <= 1'b0;
         end
         if (w_load) begin
            r_cs_n <= 1'b0;
         end else if (w_release) begin
            r_cs_n <= 1'b1;
         end
         if (w_finish) begin
            r_rx_data <= r_rx_sr;
         end
      end
   end

   // MOSI is the MSB of the transmit register, so it moves only on loads and
   // on SCLK falling edges.
   assign mosi     = r_tx_sr[DSIZE-1];
   assign sclk     = r_sclk;
   assign cs_n     = r_cs_n;
   assign byte_ack = r_byte_ack;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign busy     = r_busy;

endmodule

// File: tb/tb_spi_master_shift.sv
// Testbench for spi_master_shift: directed frames, a behavioural SPI slave and
// a scoreboard monitor that checks each received byte when rx_valid pulses.
`timescale 1ns/1ps

module tb_spi_master_shift;

   typedef struct packed {
      logic [7:0] tx;
      logic [7:0] rx;
      logic       cs_after;
      logic       ack_with;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [7:0] data_to_mosi;
   logic       spi_cs;
   logic       miso;
   logic       sclk, mosi, cs_n, byte_ack, rx_valid, busy;
   logic [7:0] rx_data;

   logic [7:0] data2;
   logic       spi_cs2;
   logic       miso2;
   logic       sclk2, mosi2, cs_n2, byte_ack2, rx_valid2, busy2;
   logic [7:0] rx_data2;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   exp_t       exp_q[$];
   logic [7:0] slave_q[$];
   logic [7:0] exp2_q[$];

   int         ack_cnt = 0;
   int         rxv_cnt = 0;
   int         load_cyc = 0;
   logic [7:0] mosi_cap = 8'd0;
   logic [7:0] s_sr = 8'd0;
   logic       prev_sclk = 1'b0;
   logic       prev_ack = 1'b0;

   int         load2 = 0;
   int         rise0 = 0;
   int         rise1 = 0;
   int         r2cnt = 0;

   spi_master_shift #(.CLK_DIV(4), .DSIZE(8)) u_dut (
      .clk(clk), .rst(rst), .data_to_mosi(data_to_mosi), .spi_cs(spi_cs),
      .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .byte_ack(byte_ack),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
   );

   spi_master_shift #(.CLK_DIV(2), .DSIZE(8)) u_dut2 (
      .clk(clk), .rst(rst), .data_to_mosi(data2), .spi_cs(spi_cs2),
      .miso(miso2), .sclk(sclk2), .mosi(mosi2), .cs_n(cs_n2), .byte_ack(byte_ack2),
      .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2)
   );

   // Second instance loops MOSI back to MISO, so it must receive what it sent.
   assign miso2 = mosi2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // kind: 0 = dut byte_ack, 1 = dut rx_valid, 2 = dut2 byte_ack, 3 = dut2 rx_valid
   task automatic wait_evt(input int kind, output int c);
      bit seen;
      seen = 1'b0;
      c = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if ((kind == 0 && byte_ack) || (kind == 1 && rx_valid) ||
             (kind == 2 && byte_ack2) || (kind == 3 && rx_valid2)) begin
            seen = 1'b1;
            c = cyc;
            break;
         end
      end
      if (!seen) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout waiting for event kind %0d (cycle %0d)", kind, cyc);
      end
   endtask

   // Scoreboard monitor and behavioural slave for the CLK_DIV=4 instance.
   always @(negedge clk) begin
      exp_t e;
      if (rx_valid) begin
         rxv_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_rx_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rx_data", rx_data, e.rx);
            chk("mosi_bits", mosi_cap, e.tx);
            chk("rx_latency", cyc - load_cyc, 68);
            chk("cs_n_at_done", cs_n, e.cs_after);
            chk("ack_with_rx", byte_ack, e.ack_with);
         end
      end
      if (byte_ack) begin
         chk("ack_one_cycle", prev_ack, 1'b0);
         ack_cnt++;
         load_cyc = cyc;
         mosi_cap = 8'd0;
         s_sr = (slave_q.size() != 0) ? slave_q.pop_front() : 8'd0;
         miso = s_sr[7];
      end else if (prev_sclk && !sclk) begin
         s_sr = {s_sr[6:0], 1'b0};
         miso = s_sr[7];
      end
      if (!prev_sclk && sclk) begin
         mosi_cap = {mosi_cap[6:0], mosi};
      end
      prev_sclk = sclk;
      prev_ack  = byte_ack;
   end

   // Scoreboard monitor for the CLK_DIV=2 instance.
   always @(negedge clk) begin
      if (rx_valid2) begin
         if (exp2_q.size() == 0) begin
            chk("unexpected_rx_valid2", 32'd1, 32'd0);
         end else begin
            chk("rx_data2", rx_data2, exp2_q.pop_front());
            chk("rx_latency2", cyc - load2, 34);
         end
      end
      if (byte_ack2) begin
         load2 = cyc;
         r2cnt = 0;
      end
      if (sclk2 && (r2cnt == 0 || r2cnt == 2) && !busy2 == 1'b0) begin
         // no action here; SCLK rise timestamps are taken in the block below
      end
   end

   // Rising-edge timestamps of SCLK on the CLK_DIV=2 instance.
   logic prev_sclk2 = 1'b0;
   always @(negedge clk) begin
      if (!prev_sclk2 && sclk2) begin
         if (r2cnt == 0) rise0 = cyc;
         if (r2cnt == 1) rise1 = cyc;
         r2cnt++;
      end
      prev_sclk2 = sclk2;
   end

   initial begin
      int c0, c1, c2, c3, a0, v0;
      rst = 1'b0;
      spi_cs = 1'b0;
      data_to_mosi = 8'd0;
      miso = 1'b0;
      spi_cs2 = 1'b0;
      data2 = 8'd0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_sclk", sclk, 1'b0);
      chk("rst_mosi", mosi, 1'b0);
      chk("rst_cs_n", cs_n, 1'b1);
      chk("rst_byte_ack", byte_ack, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte: A5 out, 3C in
      a0 = ack_cnt;
      exp_q.push_back('{tx: 8'hA5, rx: 8'h3C, cs_after: 1'b1, ack_with: 1'b0});
      slave_q.push_back(8'h3C);
      data_to_mosi = 8'hA5;
      spi_cs = 1'b1;
      wait_evt(0, c0);
      spi_cs = 1'b0;
      chk("busy_in_frame", busy, 1'b1);
      chk("cs_n_low_in_frame", cs_n, 1'b0);
      wait_evt(1, c1);
      chk("single_done_time", c1 - c0, 68);
      repeat (4) @(negedge clk);
      chk("single_ack_count", ack_cnt - a0, 1);
      repeat (6) @(negedge clk);

      // Back-to-back: 01, 80, FF in one CS_N frame
      a0 = ack_cnt;
      exp_q.push_back('{tx: 8'h01, rx: 8'hC3, cs_after: 1'b0, ack_with: 1'b1});
      exp_q.push_back('{tx: 8'h80, rx: 8'h5A, cs_after: 1'b0, ack_with: 1'b1});
      exp_q.push_back('{tx: 8'hFF, rx: 8'h96, cs_after: 1'b1, ack_with: 1'b0});
      slave_q.push_back(8'hC3);
      slave_q.push_back(8'h5A);
      slave_q.push_back(8'h96);
      data_to_mosi = 8'h01;
      spi_cs = 1'b1;
      wait_evt(0, c0);
      data_to_mosi = 8'h80;
      wait_evt(0, c1);
      chk("b2b_load2_time", c1 - c0, 68);
      data_to_mosi = 8'hFF;
      wait_evt(0, c2);
      chk("b2b_load3_time", c2 - c0, 136);
      spi_cs = 1'b0;
      wait_evt(1, c3);
      chk("b2b_cs_rise_time", c3 - c0, 204);
      chk("b2b_ack_count", ack_cnt - a0, 3);

      // Guard time: enable right after CS_N rises
      exp_q.push_back('{tx: 8'h96, rx: 8'h69, cs_after: 1'b1, ack_with: 1'b0});
      slave_q.push_back(8'h69);
      data_to_mosi = 8'h96;
      spi_cs = 1'b1;
      wait_evt(0, c0);
      spi_cs = 1'b0;
      chk("guard_time", c0 - c3, 4);
      wait_evt(1, c1);
      repeat (10) @(negedge clk);

      // Mid-byte data change and enable drop during bit 3
      a0 = ack_cnt;
      exp_q.push_back('{tx: 8'hC3, rx: 8'hA5, cs_after: 1'b1, ack_with: 1'b0});
      slave_q.push_back(8'hA5);
      data_to_mosi = 8'hC3;
      spi_cs = 1'b1;
      wait_evt(0, c0);
      repeat (26) @(negedge clk);
      data_to_mosi = 8'h3C;
      spi_cs = 1'b0;
      wait_evt(1, c1);
      repeat (20) @(negedge clk);
      chk("midbyte_ack_count", ack_cnt - a0, 1);
      chk("midbyte_cs_n_idle", cs_n, 1'b1);

      // Reset during bit 5
      data_to_mosi = 8'hFF;
      spi_cs = 1'b1;
      wait_evt(0, c0);
      spi_cs = 1'b0;
      repeat (44) @(negedge clk);
      v0 = rxv_cnt;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_cs_n", cs_n, 1'b1);
      chk("midrst_sclk", sclk, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_rx_valid", rx_valid, 1'b0);
      chk("midrst_rx_data", rx_data, 8'h00);
      rst = 1'b1;
      repeat (100) @(negedge clk);
      chk("midrst_no_rx_valid", rxv_cnt - v0, 0);

      // Divider boundary: CLK_DIV=2, loopback data 5A
      exp2_q.push_back(8'h5A);
      data2 = 8'h5A;
      spi_cs2 = 1'b1;
      wait_evt(2, c0);
      spi_cs2 = 1'b0;
      wait_evt(3, c1);
      chk("div2_first_rise", rise0 - c0, 2);
      chk("div2_sclk_period", rise1 - rise0, 4);
      chk("div2_done_time", c1 - c0, 34);

      repeat (10) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("scoreboard2_drained", exp2_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master_shift.md
# spi_master_shift

SPI mode-0 master serializer sitting directly downstream of the input FIFO stage. Takes the FIFO's byte output (`data_to_mosi`) and its transfer-enable (`spi_cs`), then drives SCLK/MOSI/CS_N to the slave MSB-first. It captures MISO into a receive byte and pulses a consumed/received strobe per byte. Back-to-back bytes run in one CS_N-low frame while the enable stays high.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; legal range 2..255.
- `DSIZE`, 8: bits per transfer; legal range 2..16.
- `clk` input, 1: system clock; all logic on the rising edge.
- `rst` input, 1: reset, synchronous, active-low.
- `data_to_mosi` input, DSIZE: byte to transmit; sampled only on a load edge.
- `spi_cs` input, 1: transfer enable from the FIFO stage; high means a byte is available.
- `miso` input, 1: serial data from the slave.
- `sclk` output, 1: SPI clock; idles low.
- `mosi` output, 1: serial data to the slave, MSB first.
- `cs_n` output, 1: slave select, active-low.
- `byte_ack` output, 1: one-cycle pulse on the load edge; upstream advances its read pointer on it.
- `rx_data` output, DSIZE: last received byte; holds its value until the next byte completes.
- `rx_valid` output, 1: one-cycle pulse when `rx_data` updates.
- `busy` output, 1: high whenever the FSM is not in IDLE.

## Operation
- Reset values: `sclk`=0, `mosi`=0, `cs_n`=1, `byte_ack`=0, `rx_data`=0, `rx_valid`=0, `busy`=0.
- Reset also clears the internal counters and shift registers and sets the FSM to IDLE.
- Internal counters:
  - `div_cnt` (8b) counts 0..CLK_DIV-1.
  - `tick` = (`div_cnt`==CLK_DIV-1).
  - `div_cnt` restarts at 0 on every state change.
  - `bit_cnt` counts 0..DSIZE-1.
- FSM states: IDLE, LOW, HIGH, HOLD.
- IDLE:
  - `cs_n`=1, `sclk`=0.
  - A guard counter must reach CLK_DIV cycles after entry before a load is allowed (minimum CS_N high time). After reset the guard is already satisfied.
  - If guard is done and `spi_cs`=1, perform a load:
    - `tx_sr`<=`data_to_mosi`, `mosi`<=`data_to_mosi[DSIZE-1]`.
    - `cs_n`<=0, `byte_ack`<=1, `bit_cnt`<=0.
    - Go to LOW.
- LOW:
  - `sclk`=0.
  - On `tick`: `sclk`<=1, `rx_sr`<={`rx_sr`[DSIZE-2:0], `miso`}, go to HIGH.
- HIGH:
  - On `tick`: `sclk`<=0.
  - If `bit_cnt`==DSIZE-1, go to HOLD.
  - Otherwise: `bit_cnt`++, shift `tx_sr` left, `mosi`<=next bit, go to LOW.
- HOLD:
  - `sclk`=0, `cs_n`=0.
  - On `tick`: `rx_data`<=`rx_sr`, `rx_valid`<=1.
  - If `spi_cs`=1 on that same edge, reload (same actions as the IDLE load, with `cs_n` staying 0) and go to LOW.
  - Otherwise `cs_n`<=1 and go to IDLE.
- `spi_cs` and `data_to_mosi` are ignored outside the load points. Dropping `spi_cs` mid-byte does not abort the byte.
- Reset mid-frame: on the next edge with `rst`=0, return to IDLE and drive `cs_n`=1, `sclk`=0. The partial byte is discarded and no `rx_valid` is issued.

## Timing
- Let T0 be the load edge.
- SCLK rising edge k (k=0..DSIZE-1) occurs at T0+(2k+1)·CLK_DIV.
- SCLK falling edge k occurs at T0+(2k+2)·CLK_DIV.
- `mosi` changes only at T0 and on SCLK falling edges, so it is stable ≥CLK_DIV cycles before each rising edge.
- MISO is sampled at each rising edge.
- `rx_valid` and the next load/`cs_n` release occur at T0+(2·DSIZE+1)·CLK_DIV. With CLK_DIV=4, DSIZE=8 this is T0+68.
- Back-to-back bytes: one load every (2·DSIZE+1)·CLK_DIV cycles, with no CS_N gap.
- After a frame ends, at least CLK_DIV IDLE cycles pass before the next load.
- `byte_ack` and `rx_valid` are never high for more than one cycle. They coincide on the HOLD reload edge.

## Test plan
- **Single byte.** Reset, then `spi_cs`=1 for one cycle with `data_to_mosi`=8'hA5 and MISO driven from 8'h3C on SCLK falls. Required: MOSI bits 1,0,1,0,0,1,0,1 at SCLK rises; `rx_data`=8'h3C with `rx_valid` at T0+68; `cs_n` high at T0+68; `byte_ack` at T0 only.
- **Back-to-back.** Hold `spi_cs`=1 and present 8'h01, 8'h80, 8'hFF. Required: `cs_n` stays low across all three; loads at T0, T0+68, T0+136; three `byte_ack` pulses; `cs_n` rises at T0+204.
- **Guard time.** After a frame ends with `spi_cs`=0, raise `spi_cs`=1 on the next cycle. Required: the load occurs exactly CLK_DIV=4 cycles after `cs_n` rises.
- **Mid-byte changes.** Change `data_to_mosi` and drop `spi_cs` during bit 3. Required: the original byte completes unchanged, and no further load occurs.
- **Reset mid-frame.** Assert `rst`=0 during bit 5. Required: next edge `cs_n`=1, `sclk`=0, `busy`=0, no `rx_valid`, and `rx_data` cleared to 0.
- **Divider boundary.** Run with CLK_DIV=2, DSIZE=8, data 8'h5A. Required: SCLK period 4 cycles; `rx_valid` at T0+34.
